// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage and its MEM/WB register bank.
package mem_stage_pkg;

    localparam int DATA_W_DEF = 16;

    // Write-back source select carried alongside the instruction
    typedef enum logic [1:0] {
        RS_PC2   = 2'b00,
        RS_MEM   = 2'b01,
        RS_ALU   = 2'b10,
        RS_CONST = 2'b11
    } reg_src_e;

    // Access state: IDLE accepts new work, WAIT holds an outstanding access
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register bank: valid follows the load strobe every cycle,
// payload fields (including the error flag) only change when a result retires.
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              err_i,
    input  logic [1:0]        reg_src_i,
    input  logic              alu_jmp_i,
    input  logic [DATA_W-1:0] alu_out_i,
    input  logic [DATA_W-1:0] read_data_i,
    input  logic [DATA_W-1:0] pc_plus_two_i,
    input  logic [DATA_W-1:0] const_sel_i,
    input  logic [DATA_W-1:0] imm_jmp_i,
    output logic              valid_o,
    output logic              err_o,
    output logic [1:0]        reg_src_o,
    output logic              alu_jmp_o,
    output logic [DATA_W-1:0] alu_out_o,
    output logic [DATA_W-1:0] read_data_o,
    output logic [DATA_W-1:0] pc_plus_two_o,
    output logic [DATA_W-1:0] const_sel_o,
    output logic [DATA_W-1:0] imm_jmp_o
);

    logic              valid_q;
    logic              err_q;
    logic [1:0]        reg_src_q;
    logic              alu_jmp_q;
    logic [DATA_W-1:0] alu_out_q;
    logic [DATA_W-1:0] read_data_q;
    logic [DATA_W-1:0] pc_plus_two_q;
    logic [DATA_W-1:0] const_sel_q;
    logic [DATA_W-1:0] imm_jmp_q;

    // Clear on reset; otherwise pulse valid per retirement and hold payload between retirements
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q       <= 1'b0;
            err_q         <= 1'b0;
            reg_src_q     <= 2'b00;
            alu_jmp_q     <= 1'b0;
            alu_out_q     <= '0;
            read_data_q   <= '0;
            pc_plus_two_q <= '0;
            const_sel_q   <= '0;
            imm_jmp_q     <= '0;
        end else begin
            valid_q <= load_i;
            if (load_i) begin
                err_q         <= err_i;
                reg_src_q     <= reg_src_i;
                alu_jmp_q     <= alu_jmp_i;
                alu_out_q     <= alu_out_i;
                read_data_q   <= read_data_i;
                pc_plus_two_q <= pc_plus_two_i;
                const_sel_q   <= const_sel_i;
                imm_jmp_q     <= imm_jmp_i;
            end
        end
    end

    assign valid_o       = valid_q;
    assign err_o         = err_q;
    assign reg_src_o     = reg_src_q;
    assign alu_jmp_o     = alu_jmp_q;
    assign alu_out_o     = alu_out_q;
    assign read_data_o   = read_data_q;
    assign pc_plus_two_o = pc_plus_two_q;
    assign const_sel_o   = const_sel_q;
    assign imm_jmp_o     = imm_jmp_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over a request/done handshake,
// stalls upstream while an access is outstanding, and retires into MEM/WB.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              flush,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        RegSrc_in,
    input  logic              ALUJmp_in,
    input  logic [DATA_W-1:0] ALU_output_in,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] pc_plus_two_in,
    input  logic [DATA_W-1:0] ConstSel_in,
    input  logic [DATA_W-1:0] ImmJmp_in,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              stall,
    output logic              wb_valid,
    output logic              wb_err,
    output logic [1:0]        wb_RegSrc,
    output logic              wb_ALUJmp,
    output logic [DATA_W-1:0] wb_ALU_output,
    output logic [DATA_W-1:0] wb_read_data,
    output logic [DATA_W-1:0] wb_pc_plus_two,
    output logic [DATA_W-1:0] wb_ConstSel,
    output logic [DATA_W-1:0] wb_ImmJmp
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              memop;
    logic              is_load;
    logic              misaligned;
    logic              accept;
    logic              issue;
    logic              at_limit;
    logic              retire;
    logic              ret_err;
    logic [DATA_W-1:0] ret_rdata;

    // A read+write combination is treated as a store, so it never returns data
    assign memop      = MemRead | MemWrite;
    assign is_load    = MemRead & ~MemWrite;
    assign misaligned = ALU_output_in[0];
    assign accept     = in_valid & ~flush & (state_q == IDLE);
    assign issue      = accept & memop & ~misaligned;
    assign at_limit   = (cnt_q == CNT_W'(TIMEOUT - 1));

    // State and wait counter register; reset abandons any outstanding access
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Enter WAIT only when the request was not answered in its own cycle; leave on done or timeout
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (issue && !mem_done) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (mem_done || at_limit) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Request strobe, stall and retirement payload; all quiet while reset is held
    always_comb begin
        mem_en    = 1'b0;
        stall     = 1'b0;
        retire    = 1'b0;
        ret_err   = 1'b0;
        ret_rdata = '0;
        if (rst) begin
            unique case (state_q)
                IDLE: begin
                    mem_en    = issue;
                    stall     = issue & ~mem_done;
                    retire    = accept & (~memop | misaligned | mem_done);
                    ret_err   = accept & memop & misaligned;
                    ret_rdata = (issue && mem_done && is_load) ? mem_rdata : '0;
                end
                WAIT: begin
                    stall     = ~mem_done & ~at_limit;
                    retire    = mem_done | at_limit;
                    ret_err   = ~mem_done;
                    ret_rdata = (mem_done && is_load) ? mem_rdata : '0;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

    assign mem_wr    = mem_en & MemWrite;
    assign mem_addr  = ALU_output_in;
    assign mem_wdata = store_data;

    mem_wb_reg #(
        .DATA_W (DATA_W)
    ) u_mem_wb_reg (
        .clk           (clk),
        .rst           (rst),
        .load_i        (retire),
        .err_i         (ret_err),
        .reg_src_i     (RegSrc_in),
        .alu_jmp_i     (ALUJmp_in),
        .alu_out_i     (ALU_output_in),
        .read_data_i   (ret_rdata),
        .pc_plus_two_i (pc_plus_two_in),
        .const_sel_i   (ConstSel_in),
        .imm_jmp_i     (ImmJmp_in),
        .valid_o       (wb_valid),
        .err_o         (wb_err),
        .reg_src_o     (wb_RegSrc),
        .alu_jmp_o     (wb_ALUJmp),
        .alu_out_o     (wb_ALU_output),
        .read_data_o   (wb_read_data),
        .pc_plus_two_o (wb_pc_plus_two),
        .const_sel_o   (wb_ConstSel),
        .imm_jmp_o     (wb_ImmJmp)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a transaction-level reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int DW = 16;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, flush, MemRead, MemWrite, ALUJmp_in, mem_done;
    logic [1:0]    RegSrc_in;
    logic [DW-1:0] ALU_output_in, store_data, pc_plus_two_in, ConstSel_in, ImmJmp_in, mem_rdata;
    logic          mem_en, mem_wr, stall, wb_valid, wb_err, wb_ALUJmp;
    logic [1:0]    wb_RegSrc;
    logic [DW-1:0] mem_addr, mem_wdata, wb_ALU_output, wb_read_data, wb_pc_plus_two, wb_ConstSel, wb_ImmJmp;

    int errors = 0;
    int checks = 0;
    int memEnCount = 0;
    int stallCount = 0;

    // Reference model state: whether an access is outstanding, how long, and the expected MEM/WB contents
    bit            modelKnown = 1'b0;
    bit            mBusy = 1'b0;
    int            mAge = 0;
    logic          eValid, eErr, eAluJmp;
    logic [1:0]    eRegSrc;
    logic [DW-1:0] eAlu, eRd, ePc, eConst, eImm;

    always #5 clk = ~clk;

    mem_stage #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegSrc_in(RegSrc_in), .ALUJmp_in(ALUJmp_in),
        .ALU_output_in(ALU_output_in), .store_data(store_data), .pc_plus_two_in(pc_plus_two_in),
        .ConstSel_in(ConstSel_in), .ImmJmp_in(ImmJmp_in),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .stall(stall),
        .wb_valid(wb_valid), .wb_err(wb_err), .wb_RegSrc(wb_RegSrc), .wb_ALUJmp(wb_ALUJmp),
        .wb_ALU_output(wb_ALU_output), .wb_read_data(wb_read_data), .wb_pc_plus_two(wb_pc_plus_two),
        .wb_ConstSel(wb_ConstSel), .wb_ImmJmp(wb_ImmJmp)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; side fields are derived from the address
    task automatic applyStimulus(input logic rstV, input logic iv, input logic fl,
                                 input logic mr, input logic mw, input logic [DW-1:0] alu,
                                 input logic [DW-1:0] sd, input logic done, input logic [DW-1:0] rdata);
        @(negedge clk);
        rst            = rstV;
        in_valid       = iv;
        flush          = fl;
        MemRead        = mr;
        MemWrite       = mw;
        ALU_output_in  = alu;
        store_data     = sd;
        pc_plus_two_in = alu + 16'd2;
        ConstSel_in    = alu ^ 16'h5A5A;
        ImmJmp_in      = ~alu;
        RegSrc_in      = mr ? RS_MEM : (mw ? RS_PC2 : RS_ALU);
        ALUJmp_in      = alu[2];
        mem_done       = done;
        mem_rdata      = rdata;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    endtask

    // Compare process: model the cycle from the rules, check strobes mid-cycle and MEM/WB after the edge
    initial begin : compareProc
        logic          xMemEn, xStall, retireNow, retErr, nBusy;
        logic [DW-1:0] retRd;
        int            nAge;
        bit            isLoad;
        forever begin
            @(negedge clk);
            #2;
            xMemEn = 1'b0; xStall = 1'b0; retireNow = 1'b0; retErr = 1'b0; retRd = '0;
            nBusy = mBusy; nAge = mAge;
            isLoad = MemRead && !MemWrite;
            if (rst && !mBusy) begin
                if (in_valid && !flush) begin
                    if (!(MemRead || MemWrite)) begin
                        retireNow = 1'b1;
                    end else if (ALU_output_in % 2 == 1) begin
                        retireNow = 1'b1;
                        retErr    = 1'b1;
                    end else begin
                        xMemEn = 1'b1;
                        if (mem_done) begin
                            retireNow = 1'b1;
                            retRd     = isLoad ? mem_rdata : '0;
                        end else begin
                            xStall = 1'b1;
                            nBusy  = 1'b1;
                            nAge   = 0;
                        end
                    end
                end
            end else if (rst && mBusy) begin
                if (mem_done) begin
                    retireNow = 1'b1;
                    retRd     = isLoad ? mem_rdata : '0;
                    nBusy     = 1'b0;
                end else if (mAge == TO - 1) begin
                    retireNow = 1'b1;
                    retErr    = 1'b1;
                    nBusy     = 1'b0;
                end else begin
                    xStall = 1'b1;
                    nAge   = mAge + 1;
                end
            end
            if (modelKnown) begin
                checkOutput("mem_en", 32'(mem_en), 32'(xMemEn));
                checkOutput("stall", 32'(stall), 32'(xStall));
                if (xMemEn) begin
                    checkOutput("mem_wr", 32'(mem_wr), 32'(MemWrite));
                    checkOutput("mem_addr", 32'(mem_addr), 32'(ALU_output_in));
                    checkOutput("mem_wdata", 32'(mem_wdata), 32'(store_data));
                end
            end
            memEnCount += int'(mem_en);
            stallCount += int'(stall);

            @(posedge clk);
            #1;
            if (!rst) begin
                modelKnown = 1'b1;
                mBusy = 1'b0; mAge = 0;
                eValid = 1'b0; eErr = 1'b0; eAluJmp = 1'b0; eRegSrc = 2'b00;
                eAlu = '0; eRd = '0; ePc = '0; eConst = '0; eImm = '0;
            end else begin
                mBusy  = nBusy;
                mAge   = nAge;
                eValid = retireNow;
                if (retireNow) begin
                    eErr    = retErr;
                    eRd     = retRd;
                    eRegSrc = RegSrc_in;
                    eAluJmp = ALUJmp_in;
                    eAlu    = ALU_output_in;
                    ePc     = pc_plus_two_in;
                    eConst  = ConstSel_in;
                    eImm    = ImmJmp_in;
                end
            end
            if (modelKnown) begin
                checkOutput("wb_valid", 32'(wb_valid), 32'(eValid));
                checkOutput("wb_err", 32'(wb_err), 32'(eErr));
                checkOutput("wb_RegSrc", 32'(wb_RegSrc), 32'(eRegSrc));
                checkOutput("wb_ALUJmp", 32'(wb_ALUJmp), 32'(eAluJmp));
                checkOutput("wb_ALU_output", 32'(wb_ALU_output), 32'(eAlu));
                checkOutput("wb_read_data", 32'(wb_read_data), 32'(eRd));
                checkOutput("wb_pc_plus_two", 32'(wb_pc_plus_two), 32'(ePc));
                checkOutput("wb_ConstSel", 32'(wb_ConstSel), 32'(eConst));
                checkOutput("wb_ImmJmp", 32'(wb_ImmJmp), 32'(eImm));
            end
        end
    end

    // Watchdog so a stuck run still reports
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "[TB] time limit");
    end

    // Directed scenarios with literal expectations
    initial begin
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        RegSrc_in = 2'b00; ALUJmp_in = 1'b0; ALU_output_in = '0; store_data = '0;
        pc_plus_two_in = '0; ConstSel_in = '0; ImmJmp_in = '0; mem_done = 1'b0; mem_rdata = '0;

        // Reset
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        #1;
        checkOutput("reset wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("reset wb_ALU_output", 32'(wb_ALU_output), 32'd0);
        checkOutput("reset stall", 32'(stall), 32'd0);

        // ALU instruction
        memEnCount = 0; stallCount = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0, 16'h0000);
        idleCycle();
        #1;
        checkOutput("alu wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("alu wb_ALU_output", 32'(wb_ALU_output), 32'h1234);
        checkOutput("alu wb_RegSrc", 32'(wb_RegSrc), 32'd2);
        checkOutput("alu stall cycles", 32'(stallCount), 32'd0);

        // Load at 0x0040, done in the third WAIT cycle
        memEnCount = 0; stallCount = 0;
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 16'hBEEF);
        idleCycle();
        #1;
        checkOutput("load wb_read_data", 32'(wb_read_data), 32'hBEEF);
        checkOutput("load wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("load wb_err", 32'(wb_err), 32'd0);
        checkOutput("load mem_en pulses", 32'(memEnCount), 32'd1);
        checkOutput("load stall cycles", 32'(stallCount), 32'd3);

        // Misaligned store
        memEnCount = 0; stallCount = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0011, 16'h5555, 1'b0, 16'h0000);
        idleCycle();
        #1;
        checkOutput("misaligned wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("misaligned wb_err", 32'(wb_err), 32'd1);
        checkOutput("misaligned mem_en pulses", 32'(memEnCount), 32'd0);

        // Load that never completes
        memEnCount = 0; stallCount = 0;
        repeat (16) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0080, 16'h0000, 1'b0, 16'h0000);
        idleCycle();
        #1;
        checkOutput("timeout wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("timeout wb_err", 32'(wb_err), 32'd1);
        checkOutput("timeout wb_read_data", 32'(wb_read_data), 32'd0);
        checkOutput("timeout stall cycles", 32'(stallCount), 32'd15);
        idleCycle();
        #1;
        checkOutput("timeout back idle wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("timeout back idle stall", 32'(stall), 32'd0);

        // Load answered in its request cycle
        memEnCount = 0; stallCount = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0042, 16'h0000, 1'b1, 16'h1357);
        idleCycle();
        #1;
        checkOutput("fast load wb_read_data", 32'(wb_read_data), 32'h1357);
        checkOutput("fast load wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("fast load stall cycles", 32'(stallCount), 32'd0);

        // Flush during WAIT is ignored
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0044, 16'h0000, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0044, 16'h0000, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0044, 16'h0000, 1'b1, 16'h2468);
        idleCycle();
        #1;
        checkOutput("wait flush wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("wait flush wb_read_data", 32'(wb_read_data), 32'h2468);

        // Flush in IDLE kills the instruction; payload holds
        memEnCount = 0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0046, 16'h0000, 1'b0, 16'h0000);
        idleCycle();
        #1;
        checkOutput("idle flush wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("idle flush mem_en pulses", 32'(memEnCount), 32'd0);
        checkOutput("idle flush wb_ALU_output hold", 32'(wb_ALU_output), 32'h0044);

        // Read and write together behave as a store
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0060, 16'hCAFE, 1'b1, 16'hAAAA);
        idleCycle();
        #1;
        checkOutput("rw wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("rw wb_read_data", 32'(wb_read_data), 32'd0);

        // Reset during WAIT, then a late done
        memEnCount = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0050, 16'h0000, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0050, 16'h0000, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0050, 16'h0000, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h7777);
        #1;
        checkOutput("mid reset wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("mid reset wb_ALU_output", 32'(wb_ALU_output), 32'd0);
        checkOutput("mid reset wb_pc_plus_two", 32'(wb_pc_plus_two), 32'd0);
        checkOutput("mid reset stall", 32'(stall), 32'd0);
        idleCycle();
        #1;
        checkOutput("late done wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("late done wb_read_data", 32'(wb_read_data), 32'd0);
        checkOutput("mid reset mem_en pulses", 32'(memEnCount), 32'd1);

        idleCycle();
        idleCycle();
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register. Sits directly upstream of the write-back stage.
- Takes the executed instruction from EX/MEM and issues a load or store to a variable-latency data memory using a request/done handshake.
- Stalls the pipeline front while the access is outstanding.
- Registers ALU_output, read_data, pc_plus_two, ConstSel_mux, ImmJmp_mux, RegSrc and ALUJmp for write-back to consume.

Parameters:
- DATA_W, 16, datapath/address width.
- TIMEOUT, 15, max wait cycles for mem_done before the access is retired with error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- in_valid  in  1  EX/MEM instruction valid
- flush  in  1  kill incoming instruction (not an in-flight access)
- MemRead  in  1  load
- MemWrite  in  1  store
- RegSrc_in  in  2  passthrough control
- ALUJmp_in  in  1  passthrough control
- ALU_output_in  in  DATA_W  address / ALU result
- store_data  in  DATA_W  store data
- pc_plus_two_in  in  DATA_W  passthrough
- ConstSel_in  in  DATA_W  passthrough
- ImmJmp_in  in  DATA_W  passthrough
- mem_en  out  1  memory request strobe
- mem_wr  out  1  1 = write
- mem_addr  out  DATA_W  memory address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid with mem_done
- mem_done  in  1  access complete (one-cycle pulse)
- stall  out  1  hold EX/MEM and earlier
- wb_valid  out  1  MEM/WB valid
- wb_err  out  1  misaligned or timed-out access
- wb_RegSrc  out  2  registered
- wb_ALUJmp  out  1  registered
- wb_ALU_output  out  DATA_W  registered
- wb_read_data  out  DATA_W  registered
- wb_pc_plus_two  out  DATA_W  registered
- wb_ConstSel  out  DATA_W  registered
- wb_ImmJmp  out  DATA_W  registered

Behaviour:
- Reset (rst=0 at clk edge): state IDLE, timeout counter 0, all wb_* outputs 0. Combinational outputs follow from IDLE with no input: mem_en=0, stall=0. Reset mid-access abandons it; a late mem_done after reset is ignored.
- Terms:
  - accept = in_valid & ~flush & state==IDLE.
  - memop = MemRead|MemWrite. MemRead and MemWrite together are treated as a write.
- Non-memory instruction (accept & ~memop): wb_* capture the inputs next edge, wb_valid=1, wb_err=0, wb_read_data=0. Latency 1, stall=0.
- Misaligned memop (accept & ALU_output_in[0]=1): no request is issued. Retires next edge with wb_valid=1, wb_err=1, wb_read_data=0, stall=0.
- Aligned memop, IDLE cycle:
  - mem_en=1 combinationally; mem_wr=MemWrite; mem_addr=ALU_output_in; mem_wdata=store_data.
  - If mem_done=1 in this same cycle: retire as below, no stall.
  - Otherwise: stall=1, wb_valid=0 next edge, state→WAIT, counter=0.
- WAIT:
  - stall=1, mem_en=0. Inputs are held stable by upstream.
  - mem_done=1: stall=0 this cycle. Next edge: wb_* capture, wb_read_data=mem_rdata if load else 0, wb_valid=1, wb_err=0, state→IDLE.
  - No mem_done and counter==TIMEOUT-1: stall=0. Retire next edge with wb_err=1, wb_read_data=0, state→IDLE.
  - Otherwise: counter increments; wb_valid=0.
- Exactly one mem_en pulse per aligned memop. mem_done in IDLE without a same-cycle request is ignored.
- flush:
  - In IDLE: incoming instruction produces wb_valid=0 next edge and no request.
  - In WAIT: ignored; the in-flight access completes normally.
- in_valid=0 in IDLE: wb_valid=0 next edge. Other wb_* fields hold their previous values.
- Counter width is $clog2(TIMEOUT+1). It never wraps: it saturates by leaving WAIT.

Decomposition:
- Shared package holds:
  - RegSrc encodings: PC2=00, MEM=01, ALU=10, CONST=11.
  - State enum: IDLE, WAIT.
  - DATA_W default.
- One natural sub-module, mem_wb_reg: the MEM/WB register bank with load enable and valid/err bits. The FSM, counter and handshake stay in mem_stage.

Test Plan:
- ALU instruction, ALU_output_in=0x1234, RegSrc_in=10 → next edge wb_valid=1, wb_ALU_output=0x1234, stall never asserted.
- Load at 0x0040, mem_done after 3 WAIT cycles with mem_rdata=0xBEEF:
  - one mem_en pulse;
  - stall=1 for exactly 3 cycles;
  - wb_read_data=0xBEEF, wb_valid=1, wb_err=0.
- Store at 0x0011 (odd) → mem_en never asserted; next edge wb_valid=1, wb_err=1.
- Load with mem_done never arriving, TIMEOUT=15 → stall high 15 cycles, then wb_valid=1, wb_err=1, wb_read_data=0, state IDLE.
- Load with mem_done in the request cycle → no stall, 1-cycle latency, correct data. flush asserted during a later WAIT is ignored.
- rst=0 during WAIT → all wb_* outputs 0, stall=0. A mem_done arriving one cycle later causes no retirement.
